// File: rtl/ci_multicycle_master.sv
// ci_multicycle_master
// Initiator for a multi-cycle custom-instruction slave. Operands arrive on a
// valid/ready stream, are buffered, and issued one at a time (ci_start/ci_dataa).
// Each result (or a timeout marker) is captured and returned, in issue order,
// on a valid/ready output stream.
module ci_multicycle_master #(
  parameter int          DEPTH       = 4,
  parameter int          TIMEOUT     = 64,
  parameter logic [31:0] TIMEOUT_VAL = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_R   = (CW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUSH  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------- input FIFO
  logic [31:0]   in_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr_reg;
  logic [AW-1:0] in_rd_ptr_reg;
  logic [CW-1:0] in_count_reg;
  logic          in_push;
  logic          in_pop;

  // ---------------------------------------------------------------- result FIFO
  logic [31:0]   res_mem [DEPTH];
  logic [AW-1:0] res_wr_ptr_reg;
  logic [AW-1:0] res_rd_ptr_reg;
  logic [CW-1:0] res_count_reg;
  logic          res_push;
  logic          res_pop;

  // ---------------------------------------------------------------- op datapath
  logic [WW-1:0] wait_cnt_reg;
  logic [31:0]   capture_reg;
  logic [31:0]   ci_dataa_reg;
  logic          err_timeout_reg;
  logic [15:0]   done_count_reg;

  logic          in_flight;
  logic [CW:0]   reserved;
  logic          wait_expired;
  logic          issue_go;

  // in_ready depends only on registered occupancy, so a pop on the same edge
  // never opens a combinational path from the FSM back to the host.
  assign in_ready  = (in_count_reg != DEPTH_C);
  assign in_push   = in_valid & in_ready;
  assign in_pop    = issue_go;

  assign out_valid = (res_count_reg != '0);
  assign res_pop   = out_valid & out_ready;
  assign res_push  = (state_reg == ST_PUSH);
  // Head entry when non-empty, zero otherwise so the idle/reset value is defined.
  assign out_data  = out_valid ? res_mem[res_rd_ptr_reg] : 32'd0;

  // An op occupies a result slot from issue until its PUSH lands in the FIFO.
  assign in_flight    = (state_reg != ST_IDLE);
  assign reserved     = {1'b0, res_count_reg} + {{CW{1'b0}}, in_flight};
  assign wait_expired = (wait_cnt_reg == WAIT_LAST);

  assign ci_start    = (state_reg == ST_ISSUE);
  assign ci_clk_en   = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign ci_dataa    = ci_dataa_reg;
  assign busy        = in_flight || (in_count_reg != '0);
  assign err_timeout = err_timeout_reg;
  assign done_count  = done_count_reg;

  // Input FIFO storage: write-only array, no reset needed (pointers define validity).
  always_ff @(posedge clock) begin
    if (in_push) begin
      in_mem[in_wr_ptr_reg] <= in_data;
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_count_reg  <= '0;
    end else begin
      if (in_push) begin
        in_wr_ptr_reg <= in_wr_ptr_reg + 1'b1;
      end
      if (in_pop) begin
        in_rd_ptr_reg <= in_rd_ptr_reg + 1'b1;
      end
      case ({in_push, in_pop})
        2'b10:   in_count_reg <= in_count_reg + 1'b1;
        2'b01:   in_count_reg <= in_count_reg - 1'b1;
        default: in_count_reg <= in_count_reg;
      endcase
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clock) begin
    if (res_push) begin
      res_mem[res_wr_ptr_reg] <= capture_reg;
    end
  end

  // Result FIFO pointers and occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_count_reg  <= '0;
    end else begin
      if (res_push) begin
        res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
      end
      if (res_pop) begin
        res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;
      end
      case ({res_push, res_pop})
        2'b10:   res_count_reg <= res_count_reg + 1'b1;
        2'b01:   res_count_reg <= res_count_reg - 1'b1;
        default: res_count_reg <= res_count_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: issue only when a result slot can be reserved, so the
  // slave is never left holding a result with nowhere to put it.
  always_comb begin
    state_next = state_reg;
    issue_go   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((in_count_reg != '0) && (reserved < DEPTH_R)) begin
          state_next = ST_ISSUE;
          issue_go   = 1'b1;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ci_done || wait_expired) begin
          state_next = ST_PUSH;
        end
      end
      ST_PUSH: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Op datapath: operand latch, wait counter, result capture, status counters.
  // A done coinciding with the last wait cycle takes priority over the timeout.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ci_dataa_reg    <= '0;
      wait_cnt_reg    <= '0;
      capture_reg     <= '0;
      err_timeout_reg <= 1'b0;
      done_count_reg  <= '0;
    end else begin
      if (issue_go) begin
        ci_dataa_reg <= in_mem[in_rd_ptr_reg];
      end
      case (state_reg)
        ST_ISSUE: wait_cnt_reg <= '0;
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (ci_done) begin
            capture_reg <= ci_result;
          end else if (wait_expired) begin
            capture_reg     <= TIMEOUT_VAL;
            err_timeout_reg <= 1'b1;
          end
        end
        ST_PUSH: done_count_reg <= done_count_reg + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ci_multicycle_master.sv
// tb_ci_multicycle_master
// Self-checking bench: a behavioural slave (result = operand ^ KEY after a
// per-op latency, latency 0 = never answers) plus an in-order scoreboard.
module tb_ci_multicycle_master;

  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 64;
  localparam logic [31:0] TOV     = 32'hFFFF_FFFF;
  localparam logic [31:0] KEY     = 32'h5A5A_0F0F;

  logic        clock = 1'b0;
  logic        aclr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_result = 32'd0;
  logic        ci_done = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic [15:0] done_count;

  ci_multicycle_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TIMEOUT_VAL(TOV)) dut (
    .clock(clock), .aclr(aclr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
    .ci_result(ci_result), .ci_done(ci_done),
    .busy(busy), .err_timeout(err_timeout), .done_count(done_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] op_q[$];   // accepted operands awaiting issue
  int          lat_q[$];  // slave latency chosen for each accepted operand
  logic [31:0] exp_q[$];  // results expected on the output stream, in order
  int          next_lat = 5;
  int          total_acc = 0;
  bit          exp_err = 1'b0;

  // Slave model state
  bit          sl_active = 1'b0;
  int          sl_start = 0;
  int          sl_lat = 0;
  logic [31:0] sl_op = 32'd0;
  bit          op_open = 1'b0;
  int          op_end = 0;
  int          last_done = -1;
  int          n_starts = 0;
  int          n_pops = 0;
  bit          gap_chk = 1'b0;

  typedef struct {
    logic [31:0] op;
    int          lat;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A result is real when the slave answers within TIMEOUT cycles of ci_start.
  function automatic logic [31:0] expect_of(input logic [31:0] op, input int lat);
    return (lat >= 1 && lat <= TIMEOUT) ? (op ^ KEY) : TOV;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"},    32'(in_ready),    32'd1);
    chk({tag, " out_valid"},   32'(out_valid),   32'd0);
    chk({tag, " out_data"},    out_data,         32'd0);
    chk({tag, " ci_start"},    32'(ci_start),    32'd0);
    chk({tag, " ci_clk_en"},   32'(ci_clk_en),   32'd0);
    chk({tag, " ci_dataa"},    ci_dataa,         32'd0);
    chk({tag, " busy"},        32'(busy),        32'd0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
    chk({tag, " done_count"},  32'(done_count),  32'd0);
  endtask

  // One clock: account for handshakes completing on this edge, advance,
  // then play the slave and check issue-side behaviour in the new cycle.
  task automatic tick();
    int pops_before;
    bit en_exp;
    pops_before = n_pops;
    if (in_valid && in_ready) begin
      op_q.push_back(in_data);
      lat_q.push_back(next_lat);
      exp_q.push_back(expect_of(in_data, next_lat));
      if (next_lat == 0 || next_lat > TIMEOUT) exp_err = 1'b1;
      total_acc++;
    end
    if (out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) chk("unexpected_result", out_data, 32'hXXXX_XXXX);
      else                   chk("result_order", out_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    cyc++;
    ci_done   = 1'b0;
    ci_result = $urandom;
    if (sl_active && cyc == sl_start + sl_lat) begin
      ci_done   = 1'b1;
      ci_result = sl_op ^ KEY;
      sl_active = 1'b0;
      last_done = cyc;
    end
    if (ci_start) begin
      n_starts++;
      if (gap_chk && last_done >= 0) chk("start_gap", 32'(cyc - last_done), 32'd3);
      if (op_q.size() == 0) begin
        chk("start_without_operand", 32'(ci_start), 32'd0);
        sl_lat = 0;
      end else begin
        chk("issue_operand", ci_dataa, op_q.pop_front());
        sl_lat = lat_q.pop_front();
      end
      chk("result_slot_reserved", 32'(n_starts - pops_before <= DEPTH), 32'd1);
      sl_active = (sl_lat >= 1 && sl_lat <= TIMEOUT);
      sl_start  = cyc;
      sl_op     = ci_dataa;
      op_open   = 1'b1;
      op_end    = cyc + (sl_active ? sl_lat : TIMEOUT);
    end
    en_exp = op_open && cyc <= op_end;
    chk("ci_clk_en", 32'(ci_clk_en), 32'(en_exp));
    if (op_open && cyc >= op_end) op_open = 1'b0;
  endtask

  task automatic wait_out(input int bound);
    for (int k = 0; k < bound && !out_valid; k++) tick();
    chk("out_valid_reached", 32'(out_valid), 32'd1);
  endtask

  task automatic clear_model();
    op_q.delete();
    lat_q.delete();
    exp_q.delete();
    sl_active = 1'b0;
    op_open   = 1'b0;
    total_acc = 0;
    exp_err   = 1'b0;
    n_starts  = 0;
    n_pops    = 0;
    last_done = -1;
  endtask

  function automatic int pick_lat(input int idx);
    if (idx == 7)  return 0;
    if (idx == 15) return TIMEOUT;
    if (idx == 16) return TIMEOUT - 1;
    return int'($urandom_range(1, 8));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cyc;
    int acc;
    int s0;
    int seen;
    int p_cyc;
    bit acc_now;
    logic [15:0] dc;

    vecs[0] = '{32'h3F00_0000, 5,       32'h655A_0F0F, 1'b0};
    vecs[1] = '{32'h0000_0000, 1,       32'h5A5A_0F0F, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 63,      32'hA5A5_F0F0, 1'b0};
    vecs[3] = '{32'h1234_5678, TIMEOUT, 32'h486E_5977, 1'b0};
    vecs[4] = '{32'h3DCC_CCCD, 0,       32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h3F80_0000, 3,       32'h65DA_0F0F, 1'b1};

    // Reset state
    #1 aclr = 1'b1;
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    aclr = 1'b0;
    tick();

    // Table-driven single ops: latency, data, timeout and sticky error
    for (int i = 0; i < 6; i++) begin
      next_lat = vecs[i].lat;
      in_data  = vecs[i].op;
      in_valid = 1'b1;
      tick();
      e_cyc    = cyc;
      in_valid = 1'b0;
      tick();
      chk("start_at_E+1", 32'(ci_start), 32'd1);
      chk("busy_in_op", 32'(busy), 32'd1);
      wait_out(TIMEOUT + 10);
      chk("result_cycle", 32'(cyc),
          32'(e_cyc + 1 + ((vecs[i].lat != 0) ? vecs[i].lat : TIMEOUT) + 2));
      chk("result_data", out_data, vecs[i].exp_data);
      chk("err_timeout", 32'(err_timeout), 32'(vecs[i].exp_err));
      chk("done_count", 32'(done_count), 32'(i + 1));
      tick();
      tick();
      chk("out_data_hold", out_data, vecs[i].exp_data);
      $display("vec %0d op=%h lat=%0d out=%h err=%0d cnt=%0d",
               i, vecs[i].op, vecs[i].lat, out_data, err_timeout, done_count);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("popped_empty", 32'(out_valid), 32'd0);
    end

    // Spurious done while idle is ignored
    dc        = done_count;
    ci_done   = 1'b1;
    ci_result = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    chk("spurious_out_valid", 32'(out_valid), 32'd0);
    chk("spurious_done_count", 32'(done_count), 32'(dc));
    chk("spurious_busy", 32'(busy), 32'd0);

    // Back-to-back ops: next ci_start exactly 3 cycles after ci_done
    out_ready = 1'b1;
    next_lat  = 4;
    last_done = -1;
    gap_chk   = 1'b1;
    acc       = 0;
    in_valid  = 1'b1;
    in_data   = 32'h3DCC_CCCD;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        acc++;
        in_data = in_data + 32'h0080_0000;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) tick();
    gap_chk = 1'b0;
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
    $display("back-to-back: %0d ops, done_count=%0d", acc, done_count);

    // Result FIFO full: only DEPTH issued, then input fills and in_ready drops
    out_ready = 1'b0;
    next_lat  = 2;
    s0        = n_starts;
    acc       = 0;
    in_valid  = 1'b1;
    in_data   = 32'h1000_0000;
    for (int k = 0; k < 80; k++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        acc++;
        in_data = in_data + 32'd1;
      end
    end
    in_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'(2 * DEPTH));
    chk("full_issued", 32'(n_starts - s0), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    p_cyc = cyc;
    chk("no_start_at_pop", 32'(ci_start), 32'd0);
    tick();
    chk("start_after_pop", 32'(ci_start), 32'd1);
    chk("start_after_pop_cycle", 32'(cyc), 32'(p_cyc + 1));
    out_ready = 1'b1;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || busy || out_valid); k++) tick();
    out_ready = 1'b0;
    chk("full_drained", 32'(exp_q.size()), 32'd0);
    $display("full test: accepted=%0d done_count=%0d", acc, done_count);

    // Randomized traffic against the scoreboard
    acc      = 0;
    in_data  = $urandom;
    next_lat = pick_lat(0);
    for (int c = 0; c < 20000 && !(acc == 40 && exp_q.size() == 0 && !busy && !out_valid); c++) begin
      in_valid  = (acc < 40) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      acc_now   = in_valid && in_ready;
      tick();
      if (acc_now) begin
        acc++;
        in_data  = $urandom;
        next_lat = pick_lat(acc);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("random_accepted", 32'(acc), 32'd40);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    chk("random_done_count", 32'(done_count), 32'(total_acc & 16'hFFFF));
    chk("random_err_timeout", 32'(err_timeout), 32'(exp_err));
    $display("random: ops=%0d done_count=%0d err=%0d", acc, done_count, err_timeout);

    // aclr during WAIT with two operands queued
    acc      = 0;
    in_valid = 1'b1;
    in_data  = 32'hAAAA_0001;
    next_lat = 0;
    for (int k = 0; k < 20 && acc < 3; k++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        acc++;
        in_data  = in_data + 32'd1;
        next_lat = 3;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_clr_busy", 32'(busy), 32'd1);
    chk("pre_clr_clk_en", 32'(ci_clk_en), 32'd1);
    #2 aclr = 1'b1;
    #1;
    check_reset_outputs("aclr");
    clear_model();
    tick();
    aclr = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_result_after_clr", 32'(seen), 32'd0);
    chk("no_start_after_clr", 32'(n_starts), 32'd0);
    next_lat = 2;
    in_data  = 32'h4049_0FDB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(20);
    chk("post_clr_data", out_data, 32'h1A13_00D4);
    chk("post_clr_done_count", 32'(done_count), 32'd1);
    chk("post_clr_err", 32'(err_timeout), 32'd0);
    $display("post-aclr op: out=%h done_count=%0d", out_data, done_count);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
